// File: rtl/morph_seq_pkg.sv
// morph_seq_pkg: opcode field layout and sequencer state encoding
`define OPCODE_WIDTH 16
package morph_seq_pkg;
  localparam int EL_W = 9;
  localparam int MOP_W = 3;
  localparam int LOP_W = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_TX_REQ = 3'd4;
  localparam logic [2:0] ST_TX_WAIT = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    FETCH = ST_FETCH,
    ISSUE = ST_ISSUE,
    WAIT = ST_WAIT,
    TX_REQ = ST_TX_REQ,
    TX_WAIT = ST_TX_WAIT,
    DONE = ST_DONE
  } state_t;
  typedef struct packed {
    logic [EL_W-1:0] el;
    logic [MOP_W-1:0] morph_op;
    logic morph_in_select;
    logic [LOP_W-1:0] logic_op;
  } opcode_t;
endpackage

// File: rtl/morph_opcode_ram.sv
// morph_opcode_ram: 1W/1R synchronous opcode store, read latency 1
module morph_opcode_ram #(
  parameter int ProgAddrWidth = 3,
  parameter int OpcodeWidth = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ProgAddrWidth-1:0] waddr,
  input  logic [OpcodeWidth-1:0]   wdata,
  input  logic [ProgAddrWidth-1:0] raddr,
  output logic [OpcodeWidth-1:0]   rdata
);
  logic [OpcodeWidth-1:0] r_mem [2**ProgAddrWidth];
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end
endmodule

// File: rtl/morph_program_sequencer.sv
// morph_program_sequencer: runs a loadable opcode program, then hands off to serial TX (MORPH_SEQ_STEP_EN adds single-step input)
module morph_program_sequencer
  import morph_seq_pkg::*;
#(
  parameter int ProgAddrWidth = 3,
  parameter int OpcodeWidth = `OPCODE_WIDTH,
  parameter int OpLatency = 2
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef MORPH_SEQ_STEP_EN
  input  logic                     step,
`endif
  input  logic                     prog_we,
  input  logic [ProgAddrWidth-1:0] prog_addr,
  input  logic [OpcodeWidth-1:0]   prog_wdata,
  input  logic [ProgAddrWidth:0]   prog_len,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     proc_ce,
  output logic                     proc_first,
  output logic [OpcodeWidth-1:0]   opcode,
  output logic                     tx_start,
  input  logic                     tx_busy
);
  localparam int LW = $clog2(OpLatency + 1);
  localparam int Depth = 1 << ProgAddrWidth;
  state_t r_state, w_next;
  logic [ProgAddrWidth-1:0] r_pc;
  logic [ProgAddrWidth:0] r_len;
  logic [LW-1:0] r_lat;
  logic r_err;
  logic [OpcodeWidth-1:0] w_rdata;
  logic w_len_ok, w_last, w_step, w_accept;
`ifdef MORPH_SEQ_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b1;
`endif
  assign w_len_ok = prog_len != '0 && prog_len <= (ProgAddrWidth+1)'(Depth);
  assign w_accept = r_state == IDLE && start && w_len_ok;
  assign w_last = {1'b0, r_pc} == r_len - (ProgAddrWidth+1)'(1);
  morph_opcode_ram #(.ProgAddrWidth(ProgAddrWidth), .OpcodeWidth(OpcodeWidth)) u_ram (
    .clk(clk),
    .we(prog_we && !busy),
    .waddr(prog_addr),
    .wdata(prog_wdata),
    .raddr(r_pc),
    .rdata(w_rdata)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? FETCH : IDLE;
      FETCH: w_next = w_step ? ISSUE : FETCH;
      ISSUE: w_next = WAIT;
      WAIT: w_next = r_lat == LW'(1) ? (w_last ? TX_REQ : FETCH) : WAIT;
      TX_REQ: w_next = tx_busy ? TX_WAIT : TX_REQ;
      TX_WAIT: w_next = tx_busy ? TX_WAIT : DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_len <= '0;
      r_lat <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err <= r_state == IDLE && start && !w_len_ok;
      if (w_accept) begin
        r_len <= prog_len;
        r_pc <= '0;
      end
      if (r_state == ISSUE) r_lat <= LW'(OpLatency);
      else if (r_state == WAIT) begin
        r_lat <= r_lat - LW'(1);
        if (r_lat == LW'(1) && !w_last) r_pc <= r_pc + 1'b1;
      end
    end
  end
  assign busy = r_state != IDLE && r_state != DONE;
  assign done = r_state == DONE;
  assign err = r_err;
  assign proc_ce = r_state == ISSUE;
  assign proc_first = proc_ce && r_pc == '0;
  assign opcode = proc_ce ? w_rdata : '0;
  assign tx_start = r_state == TX_REQ;
endmodule

// File: tb/tb_morph_program_sequencer.sv
// tb_morph_program_sequencer: randomized runs checked against a cycle-arithmetic reference model
module tb_morph_program_sequencer;
  localparam int AW = 3;
  localparam int L = 2;
  localparam int D = 8;
  logic clk = 0, rst = 1, prog_we = 0, start = 0, tx_busy = 0;
  logic [AW-1:0] prog_addr = 0;
  logic [AW:0] prog_len = 0;
  logic [15:0] prog_wdata = 0;
  logic busy, done, err, proc_ce, proc_first, tx_start;
  logic [15:0] opcode;
`ifdef MORPH_SEQ_STEP_EN
  logic step = 1;
`endif
  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] mem [D];
  int pq_cyc[$];
  logic [15:0] pq_op[$];
  logic pq_first[$];
  int dq[$];
  int txs_n = 0, txs_first = 0, err_n = 0, busy_n = 0;
  int tx_dly = 3, tx_hold = 10, tx_k = 0;
  bit tx_act = 0;

  morph_program_sequencer #(.ProgAddrWidth(AW), .OpcodeWidth(16), .OpLatency(L)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MORPH_SEQ_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_wdata(prog_wdata),
    .prog_len(prog_len),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err),
    .proc_ce(proc_ce),
    .proc_first(proc_first),
    .opcode(opcode),
    .tx_start(tx_start),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (proc_ce) begin
      pq_cyc.push_back(cyc);
      pq_op.push_back(opcode);
      pq_first.push_back(proc_first);
    end
    if (tx_start) begin
      if (txs_n == 0) txs_first = cyc;
      txs_n++;
    end
    if (done) dq.push_back(cyc);
    if (err) err_n++;
    if (busy) busy_n++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (!tx_act && tx_start) begin
      tx_act = 1;
      tx_k = 0;
    end
    if (tx_act) begin
      if (tx_k == tx_dly) tx_busy = 1;
      if (tx_k == tx_dly + tx_hold) begin
        tx_busy = 0;
        tx_act = 0;
      end
      tx_k++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pq_cyc.delete();
    pq_op.delete();
    pq_first.delete();
    dq.delete();
    txs_n = 0;
    err_n = 0;
    busy_n = 0;
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1;
    prog_addr = a;
    prog_wdata = d;
    mem[a] = d;
    tick();
    prog_we = 0;
  endtask

  task automatic run_prog(input int len, input bit noise, input bit wr, input logic [AW-1:0] wa, input logic [15:0] wd);
    int c, t, to, n;
    clr();
    prog_len = (AW+1)'(len);
    start = 1;
    if (wr) begin
      prog_we = 1;
      prog_addr = wa;
      prog_wdata = wd;
      mem[wa] = wd;
    end
    c = cyc;
    tick();
    start = 0;
    prog_we = 0;
    to = 0;
    while (dq.size() == 0 && to < 3000) begin
      if (noise && busy) begin
        prog_we = 1'($urandom);
        prog_addr = AW'($urandom);
        prog_wdata = 16'($urandom);
        start = 1'($urandom);
        prog_len = (AW+1)'($urandom_range(1, 8));
      end else begin
        prog_we = 0;
        start = 0;
      end
      tick();
      to++;
    end
    prog_we = 0;
    start = 0;
    t = c + 2 + (len - 1) * (L + 2) + L + 1;
    checks++;
    if (dq.size() != 1) begin
      errors++;
      $display("FAIL run_done_count len=%0d got %0d exp 1", len, dq.size());
    end
    checks++;
    if (pq_cyc.size() != len) begin
      errors++;
      $display("FAIL pce_count len=%0d got %0d exp %0d", len, pq_cyc.size(), len);
    end
    n = pq_cyc.size() < len ? pq_cyc.size() : len;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (pq_cyc[k] !== c + 2 + k * (L + 2) || pq_op[k] !== mem[k] || pq_first[k] !== (k == 0)) begin
        errors++;
        $display("FAIL op%0d got cyc=%0d op=%h first=%b exp cyc=%0d op=%h first=%b", k,
                 pq_cyc[k] - c, pq_op[k], pq_first[k], 2 + k * (L + 2), mem[k], k == 0);
      end
    end
    checks++;
    if (txs_first !== t || txs_n !== tx_dly + 1) begin
      errors++;
      $display("FAIL tx_start got first=%0d n=%0d exp first=%0d n=%0d", txs_first - c, txs_n, t - c, tx_dly + 1);
    end
    if (dq.size() == 1) begin
      checks++;
      if (dq[0] !== t + tx_dly + tx_hold + 1 || busy_n !== dq[0] - c - 1) begin
        errors++;
        $display("FAIL done_timing got done=%0d busy_n=%0d exp done=%0d busy_n=%0d", dq[0] - c, busy_n,
                 t + tx_dly + tx_hold + 1 - c, t + tx_dly + tx_hold - c);
      end
    end
    checks++;
    if (err_n != 0) begin
      errors++;
      $display("FAIL run_err got %0d exp 0", err_n);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++;
    if ({busy, done, err, proc_ce, proc_first, tx_start, opcode} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {busy, done, err, proc_ce, proc_first, tx_start, opcode});
    end
    rst = 0;
    tick();
    checks++;
    if ({busy, done, err, proc_ce, proc_first, tx_start, opcode} !== 22'd0) begin
      errors++;
      $display("FAIL idle_outputs got %h exp 0", {busy, done, err, proc_ce, proc_first, tx_start, opcode});
    end
  endtask

  task automatic test_basic();
    wr_word(0, 16'h5D11);
    wr_word(1, 16'h4911);
    tx_dly = 3;
    tx_hold = 10;
    run_prog(2, 0, 0, 0, 0);
    run_prog(2, 0, 1, 3'd1, 16'h1234);
  endtask

  task automatic test_err();
    int lens[3];
    lens[0] = 0;
    lens[1] = 9;
    lens[2] = $urandom_range(10, 15);
    for (int i = 0; i < 3; i++) begin
      clr();
      prog_len = (AW+1)'(lens[i]);
      start = 1;
      tick();
      start = 0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse len=%0d got err=%b busy=%b exp err=1 busy=0", lens[i], err, busy);
      end
      repeat (6) tick();
      checks++;
      if (err_n != 1 || pq_cyc.size() != 0 || busy_n != 0) begin
        errors++;
        $display("FAIL err_quiet len=%0d got err_n=%0d pce=%0d busy_n=%0d exp 1 0 0", lens[i], err_n, pq_cyc.size(), busy_n);
      end
    end
  endtask

  task automatic test_full();
    for (int a = 0; a < D; a++) wr_word(AW'(a), 16'hA000 | 16'(a << 4) | 16'(a));
    tx_dly = 2;
    tx_hold = 4;
    run_prog(8, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int to;
    clr();
    prog_len = 3;
    start = 1;
    tick();
    start = 0;
    to = 0;
    while (pq_cyc.size() < 2 && to < 100) begin
      tick();
      to++;
    end
    checks++;
    if (pq_cyc.size() != 2) begin
      errors++;
      $display("FAIL rst_mid_reach got %0d exp 2", pq_cyc.size());
    end
    rst = 1;
    tick();
    checks++;
    if ({busy, done, err, proc_ce, proc_first, tx_start, opcode} !== 22'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h exp 0", {busy, done, err, proc_ce, proc_first, tx_start, opcode});
    end
    rst = 0;
    clr();
    repeat (20) tick();
    checks++;
    if (pq_cyc.size() != 0 || dq.size() != 0 || txs_n != 0 || busy_n != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet got pce=%0d done=%0d tx=%0d busy=%0d exp 0", pq_cyc.size(), dq.size(), txs_n, busy_n);
    end
    run_prog(3, 0, 0, 0, 0);
  endtask

  task automatic test_busy_ignore();
    for (int a = 0; a < D; a++) wr_word(AW'(a), 16'($urandom));
    tx_dly = 1;
    tx_hold = 5;
    run_prog(5, 1, 0, 0, 0);
    run_prog(8, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < D; a++) wr_word(AW'(a), 16'($urandom));
      tx_dly = $urandom_range(0, 4);
      tx_hold = $urandom_range(1, 6);
      run_prog($urandom_range(1, 8), 1'($urandom), 1'($urandom), AW'($urandom), 16'($urandom));
    end
  endtask

`ifdef MORPH_SEQ_STEP_EN
  task automatic test_step();
    int to;
    clr();
    step = 0;
    prog_len = 4;
    start = 1;
    tick();
    start = 0;
    repeat (20) tick();
    checks++;
    if (pq_cyc.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL step_hold got pce=%0d busy=%b exp 0 1", pq_cyc.size(), busy);
    end
    for (int i = 0; i < 3; i++) begin
      step = 1;
      tick();
      step = 0;
      repeat (8) tick();
    end
    checks++;
    if (pq_cyc.size() != 3) begin
      errors++;
      $display("FAIL step_count got %0d exp 3", pq_cyc.size());
    end
    for (int k = 0; k < 3 && k < pq_op.size(); k++) begin
      checks++;
      if (pq_op[k] !== mem[k]) begin
        errors++;
        $display("FAIL step_op%0d got %h exp %h", k, pq_op[k], mem[k]);
      end
    end
    step = 1;
    to = 0;
    while (dq.size() == 0 && to < 500) begin
      tick();
      to++;
    end
    checks++;
    if (dq.size() != 1 || pq_cyc.size() != 4) begin
      errors++;
      $display("FAIL step_finish got done=%0d pce=%0d exp 1 4", dq.size(), pq_cyc.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_full();
    test_reset_mid();
    test_busy_ignore();
    test_random();
`ifdef MORPH_SEQ_STEP_EN
    test_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
